// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_pkg
//  Description : Shared pc_ctrl encodings, BTB counter encodings and the
//                saturating 2-bit counter helper for the fetch PC generator.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_gen_pkg;

  // pc_ctrl encoding carried down the pipeline with each instruction
  typedef enum logic [1:0] {
    PC_CTRL_BRANCH = 2'b00,
    PC_CTRL_JALR   = 2'b01,
    PC_CTRL_SEQ    = 2'b10,
    PC_CTRL_JAL    = 2'b11
  } pc_ctrl_e;

  // 2-bit branch direction counter; bit 1 set means "predict taken"
  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  // Saturating counter step toward the observed outcome
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] result;
    result = ctr;
    if (taken && (ctr != CTR_STRONG_T)) begin
      result = ctr + 2'd1;
    end else if (!taken && (ctr != CTR_STRONG_NT)) begin
      result = ctr - 2'd1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_if
//  Description : Fetch/EX side bundle of the PC generator. The master side
//                drives stall and EX resolution; the slave side (pc_gen)
//                returns the fetch PC, prediction and redirect.
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            ex_valid;
  logic [1:0]      ex_pc_ctrl;
  logic [XLEN-1:0] ex_pc;
  logic            ex_branch;
  logic [XLEN-1:0] ex_alu_out;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_pred_npc;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pred_npc;
  logic            pred_taken;
  logic            redirect;
  logic [31:0]     mispred_cnt;

  modport master (
    output stall, ex_valid, ex_pc_ctrl, ex_pc, ex_branch,
           ex_alu_out, ex_imm, ex_pred_npc,
    input  pc, pred_npc, pred_taken, redirect, mispred_cnt
  );

  modport slave (
    input  stall, ex_valid, ex_pc_ctrl, ex_pc, ex_branch,
           ex_alu_out, ex_imm, ex_pred_npc,
    output pc, pred_npc, pred_taken, redirect, mispred_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pc_btb.sv
`default_nettype none
// ============================================================================
//  Module      : pc_btb
//  Description : Direct-mapped branch target buffer with 2-bit direction
//                counters. One combinational lookup port, one update port.
//                Lookup always reflects contents before the current edge.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_btb
  import pc_gen_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 8
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic [XLEN-1:0] lookup_pc_i,
  output logic                 pred_taken_o,
  output logic [XLEN-1:0]      pred_target_o,
  input  wire logic            upd_en_i,
  input  wire logic [XLEN-1:0] upd_pc_i,
  input  wire logic            upd_jal_i,
  input  wire logic            upd_taken_i,
  input  wire logic [XLEN-1:0] upd_target_i
);
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [BTB_ENTRIES-1:0] jal_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];

  logic [IDX-1:0]   w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic [IDX-1:0]   w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic             w_unused_bits;

  assign w_lk_idx = lookup_pc_i[IDX+1:2];
  assign w_lk_tag = lookup_pc_i[XLEN-1:IDX+2];
  assign w_lk_hit = valid_q[w_lk_idx] && (tag_q[w_lk_idx] == w_lk_tag);

  // Jumps are always taken on a hit; branches follow the counter MSB
  assign pred_taken_o  = w_lk_hit && (jal_q[w_lk_idx] || ctr_q[w_lk_idx][1]);
  assign pred_target_o = target_q[w_lk_idx];

  assign w_up_idx = upd_pc_i[IDX+1:2];
  assign w_up_tag = upd_pc_i[XLEN-1:IDX+2];
  assign w_up_hit = valid_q[w_up_idx] && (tag_q[w_up_idx] == w_up_tag);

  // Instructions are word aligned, the low address bits carry no information
  assign w_unused_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  // Valid bits: cleared on reset, set only when a taken miss allocates
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (upd_en_i && !w_up_hit && upd_taken_i) begin
      valid_q[w_up_idx] <= 1'b1;
    end
  end

  // Entry payload: train on hit, allocate weakly-taken on a taken miss
  always_ff @(posedge clk) begin
    if (upd_en_i) begin
      if (w_up_hit) begin
        target_q[w_up_idx] <= upd_target_i;
        jal_q[w_up_idx]    <= upd_jal_i;
        if (!upd_jal_i) begin
          ctr_q[w_up_idx] <= ctr_next(ctr_q[w_up_idx], upd_taken_i);
        end
      end else if (upd_taken_i) begin
        tag_q[w_up_idx]    <= w_up_tag;
        target_q[w_up_idx] <= upd_target_i;
        jal_q[w_up_idx]    <= upd_jal_i;
        ctr_q[w_up_idx]    <= CTR_WEAK_T;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen
//  Description : Fetch-stage PC generator. Holds the fetch PC, predicts the
//                next PC via the BTB, resolves EX control flow and redirects
//                on mispredict, counting mispredicts with saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 8,
  parameter int              IMM_SHIFT   = 1
) (
  input  wire logic  clk,
  input  wire logic  rst,
  pc_gen_if.slave    bus
);
  localparam logic [XLEN-1:0] C_INSN_BYTES = XLEN'(4);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_ex_seq;
  logic [XLEN-1:0] w_resolved;
  logic            w_redirect;
  logic            w_upd_en;
  logic            w_upd_jal;
  logic            w_upd_taken;
  logic            w_btb_taken;
  logic [XLEN-1:0] w_btb_target;
  logic [XLEN-1:0] w_pred_npc;

  assign w_br_target = bus.ex_pc + (bus.ex_imm << IMM_SHIFT);
  assign w_ex_seq    = bus.ex_pc + C_INSN_BYTES;

  // Architectural next PC of the EX instruction
  always_comb begin
    w_resolved = w_ex_seq;
    case (bus.ex_pc_ctrl)
      PC_CTRL_BRANCH: w_resolved = bus.ex_branch ? w_br_target : w_ex_seq;
      PC_CTRL_JALR:   w_resolved = bus.ex_alu_out;
      PC_CTRL_SEQ:    w_resolved = w_ex_seq;
      PC_CTRL_JAL:    w_resolved = w_br_target;
      default:        w_resolved = w_ex_seq;
    endcase
  end

  assign w_redirect = bus.ex_valid && (w_resolved != bus.ex_pred_npc);

  // Only PC-relative control flow is cached; JALR targets are data dependent
  assign w_upd_jal   = (bus.ex_pc_ctrl == PC_CTRL_JAL);
  assign w_upd_en    = bus.ex_valid && ((bus.ex_pc_ctrl == PC_CTRL_BRANCH) || w_upd_jal);
  assign w_upd_taken = w_upd_jal || bus.ex_branch;

  pc_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc_i   (pc_q),
    .pred_taken_o  (w_btb_taken),
    .pred_target_o (w_btb_target),
    .upd_en_i      (w_upd_en),
    .upd_pc_i      (bus.ex_pc),
    .upd_jal_i     (w_upd_jal),
    .upd_taken_i   (w_upd_taken),
    .upd_target_i  (w_br_target)
  );

  assign w_pred_npc = w_btb_taken ? w_btb_target : (pc_q + C_INSN_BYTES);

  // Next fetch PC: a redirect overrides a stall
  always_comb begin
    pc_d = w_pred_npc;
    if (w_redirect) begin
      pc_d = w_resolved;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end
  end

  // Mispredict count holds once it reaches all ones
  always_comb begin
    cnt_d = cnt_q;
    if (w_redirect && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Fetch PC and mispredict counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pred_npc    = w_pred_npc;
  assign bus.pred_taken  = w_btb_taken;
  assign bus.redirect    = w_redirect;
  assign bus.mispred_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_gen
//  Description : Directed self-checking bench for pc_gen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_gen;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(
    .XLEN        (32),
    .RESET_PC    (32'h0),
    .BTB_ENTRIES (8),
    .IMM_SHIFT   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_drive(input logic [1:0] ctrl, input logic [31:0] epc, input logic br,
                          input logic [31:0] alu, input logic [31:0] imm, input logic [31:0] pred);
    bus.ex_valid    = 1'b1;
    bus.ex_pc_ctrl  = ctrl;
    bus.ex_pc       = epc;
    bus.ex_branch   = br;
    bus.ex_alu_out  = alu;
    bus.ex_imm      = imm;
    bus.ex_pred_npc = pred;
  endtask

  // Force the fetch PC to an address through a mispredicted JALR
  task automatic jalr_to(input logic [31:0] addr);
    ex_drive(2'b01, 32'h300, 1'b0, addr, 32'h0, addr ^ 32'h4);
    step();
    bus.ex_valid = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.ex_valid    = 1'b0;
    bus.ex_pc_ctrl  = 2'b10;
    bus.ex_pc       = '0;
    bus.ex_branch   = 1'b0;
    bus.ex_alu_out  = '0;
    bus.ex_imm      = '0;
    bus.ex_pred_npc = '0;

    // Reset and free run
    step();
    rst = 1'b0;
    #1;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_pred_npc", bus.pred_npc, 32'h4);
    check("rst_pred_taken", 32'(bus.pred_taken), 32'h0);
    check("rst_redirect", 32'(bus.redirect), 32'h0);
    check("rst_cnt", bus.mispred_cnt, 32'h0);
    step();
    check("run_pc4", bus.pc, 32'h4);
    step();
    check("run_pc8", bus.pc, 32'h8);

    // Stall holds the PC
    bus.stall = 1'b1;
    step(); step(); step();
    check("stall_hold", bus.pc, 32'h8);
    bus.stall = 1'b0;
    step();
    check("stall_release", bus.pc, 32'hC);

    // Taken branch mispredicted as sequential
    ex_drive(2'b00, 32'h10, 1'b1, 32'h0, 32'h8, 32'h14);
    #1;
    check("b_taken_redirect", 32'(bus.redirect), 32'h1);
    step();
    bus.ex_valid = 1'b0;
    #1;
    check("b_taken_pc", bus.pc, 32'h20);
    check("b_taken_cnt", bus.mispred_cnt, 32'h1);
    jalr_to(32'h10);
    #1;
    check("btb_alloc_npc", bus.pred_npc, 32'h20);
    check("btb_alloc_taken", 32'(bus.pred_taken), 32'h1);
    check("jalr_cnt", bus.mispred_cnt, 32'h2);

    // Branch resolves not-taken twice while fetch is stalled at 0x10
    bus.stall = 1'b1;
    ex_drive(2'b00, 32'h10, 1'b0, 32'h0, 32'h8, 32'h14);
    #1;
    check("b_nt_no_redirect", 32'(bus.redirect), 32'h0);
    check("b_nt_preedge_npc", bus.pred_npc, 32'h20);
    step();
    check("ctr_01_npc", bus.pred_npc, 32'h14);
    step();
    bus.ex_valid = 1'b0;
    #1;
    check("ctr_00_npc", bus.pred_npc, 32'h14);
    check("ctr_00_taken", 32'(bus.pred_taken), 32'h0);
    check("ctr_00_pc", bus.pc, 32'h10);

    // JALR redirect beats stall and is not cached
    ex_drive(2'b01, 32'h30, 1'b0, 32'h100, 32'h0, 32'h24);
    #1;
    check("jalr_stall_redirect", 32'(bus.redirect), 32'h1);
    step();
    bus.ex_valid = 1'b0;
    bus.stall    = 1'b0;
    #1;
    check("jalr_stall_pc", bus.pc, 32'h100);
    check("jalr_stall_cnt", bus.mispred_cnt, 32'h3);
    jalr_to(32'h30);
    #1;
    check("jalr_not_cached_taken", 32'(bus.pred_taken), 32'h0);
    check("jalr_not_cached_npc", bus.pred_npc, 32'h34);

    // JAL allocates and then predicts its target
    ex_drive(2'b11, 32'h40, 1'b0, 32'h0, 32'h20, 32'h44);
    step();
    bus.ex_valid = 1'b0;
    #1;
    check("jal_pc", bus.pc, 32'h80);
    check("jal_cnt", bus.mispred_cnt, 32'h5);
    jalr_to(32'h40);
    #1;
    check("jal_pred_npc", bus.pred_npc, 32'h80);
    check("jal_pred_taken", 32'(bus.pred_taken), 32'h1);

    // Sequential wrap at the top of the address space
    jalr_to(32'hFFFF_FFFC);
    #1;
    check("wrap_pred_npc", bus.pred_npc, 32'h0);
    check("wrap_pred_taken", 32'(bus.pred_taken), 32'h0);
    step();
    check("wrap_pc", bus.pc, 32'h0);
    check("wrap_cnt", bus.mispred_cnt, 32'h7);

    // Reset wins over a simultaneous redirect and clears the BTB
    ex_drive(2'b01, 32'h300, 1'b0, 32'h200, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    check("rst_redir_pending", 32'(bus.redirect), 32'h1);
    step();
    rst          = 1'b0;
    bus.ex_valid = 1'b0;
    #1;
    check("rst_redir_pc", bus.pc, 32'h0);
    check("rst_redir_cnt", bus.mispred_cnt, 32'h0);
    jalr_to(32'h40);
    #1;
    check("rst_btb_miss_taken", 32'(bus.pred_taken), 32'h0);
    check("rst_btb_miss_npc", bus.pred_npc, 32'h44);
    check("rst_cnt_restart", bus.mispred_cnt, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
